// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C command sequencer: FSM states, command record,
// error codes, I2C master register map and config-word bit layout.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, CFG_DIV, LD_ADDR, LD_D0, LD_D1, KICK, POLL_RD, POLL_GAP_S, CHECK, DONE
  } seq_state_t;

  typedef struct packed {
    logic [6:0]  dev_addr;
    logic [15:0] data;
  } cmd_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // I2C master register map
  localparam logic [7:0] I2C_CONFIG_REG_ADDR      = 8'h00;
  localparam logic [7:0] I2C_STATUS_REG_ADDR      = 8'h04;
  localparam logic [7:0] I2C_CLK_DIV_REG_ADDR     = 8'h08;
  localparam logic [7:0] I2C_ADDR_REG_ADDR        = 8'h0C;
  localparam logic [7:0] I2C_DATA_CACHE_BASE_ADDR = 8'h10;

  localparam int CFG_START_BIT    = 0;
  localparam int CFG_STOP_BIT     = 1;
  localparam int CFG_INIT_BIT     = 2;
  localparam int CFG_RD_N_WR_BIT  = 3;
  localparam int CFG_NBYTES_LSB   = 8;
  localparam int NUM_BYTES_IDX    = 4;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_NACK_BIT    = 1;

  function automatic logic [15:0] kick_word(input logic [NUM_BYTES_IDX-1:0] nbytes);
    logic [15:0] w;
    w = '0;
    w[CFG_START_BIT]   = 1'b1;
    w[CFG_STOP_BIT]    = 1'b1;
    w[CFG_INIT_BIT]    = 1'b1;
    w[CFG_RD_N_WR_BIT] = 1'b0;
    w[CFG_NBYTES_LSB +: NUM_BYTES_IDX] = nbytes;
    return w;
  endfunction

endpackage

// File: rtl/i2c_seq_fifo.sv
// Synchronous command FIFO, registered pointers with a wrap bit; head visible combinationally.
// Push ignored when full, pop ignored when empty; simultaneous push and pop both take effect.
module i2c_seq_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/i2c_seq_ctrl.sv
// Queues 2-byte I2C writes and drives them through the I2C master's local bus, polling status.
// One LB op in flight, each held until its response; I2C_SEQ_RETRY_EN enables NACK re-issue.
module i2c_seq_ctrl
  import i2c_seq_pkg::*;
#(
  parameter int LB_DATA_W     = 32,
  parameter int LB_ADDR_W     = 8,
  parameter int CLK_DIV_CNT_W = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int POLL_GAP      = 16,
  parameter int POLL_MAX      = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [6:0]               cmd_dev_addr,
  input  logic [15:0]              cmd_data,
  input  logic [CLK_DIV_CNT_W-1:0] cfg_clk_div,
  output logic                     lb_wr_en,
  output logic                     lb_rd_en,
  output logic [LB_ADDR_W-1:0]     lb_addr,
  output logic [LB_DATA_W-1:0]     lb_wr_data,
  input  logic                     lb_wr_valid,
  input  logic                     lb_rd_valid,
  input  logic [LB_DATA_W-1:0]     lb_rd_data,
  output logic                     busy,
  output logic                     done_pulse,
  output logic                     err_pulse,
  output logic [1:0]               err_code
);
  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [15:0] KICK_WORD = kick_word(NUM_BYTES_IDX'(2));

  seq_state_t state, state_nxt;
  cmd_t       cmd_in, head;
  logic       fifo_full, fifo_empty, pop;
  logic       req_sent, shadow_vld, shadow_ld, nack_lat, nack_ld;
  logic       poll_inc, poll_clr, set_done, set_err;
  logic [1:0] err_val;
  logic [CLK_DIV_CNT_W-1:0] div_shadow, div_sample;
  logic [PCW-1:0] poll_cnt;
  logic [GCW-1:0] gap_cnt;
  logic           rd_data_unused;

  assign rd_data_unused = ^lb_rd_data;
  assign cmd_in    = '{dev_addr: cmd_dev_addr, data: cmd_data};
  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  i2c_seq_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_valid),
    .push_dat (cmd_in),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef I2C_SEQ_RETRY_EN
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RCW-1:0] retry_cnt;
  logic           retry_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            retry_cnt <= '0;
    else if (pop)       retry_cnt <= '0;
    else if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_nxt  = state;
    lb_wr_en   = 1'b0;
    lb_rd_en   = 1'b0;
    lb_addr    = '0;
    lb_wr_data = '0;
    pop        = 1'b0;
    shadow_ld  = 1'b0;
    nack_ld    = 1'b0;
    poll_inc   = 1'b0;
    poll_clr   = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    err_val    = ERR_NONE;
`ifdef I2C_SEQ_RETRY_EN
    retry_inc  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!shadow_vld || (div_shadow != cfg_clk_div)) state_nxt = CFG_DIV;
        else if (!fifo_empty)                           state_nxt = LD_ADDR;
      end
      CFG_DIV: begin
        lb_wr_en   = !req_sent;
        lb_addr    = LB_ADDR_W'(I2C_CLK_DIV_REG_ADDR);
        lb_wr_data = LB_DATA_W'(div_sample);
        if (lb_wr_valid) begin
          shadow_ld = 1'b1;
          state_nxt = IDLE;
        end
      end
      LD_ADDR: begin
        lb_wr_en   = !req_sent;
        lb_addr    = LB_ADDR_W'(I2C_ADDR_REG_ADDR);
        lb_wr_data = LB_DATA_W'({head.dev_addr, 1'b0});
        if (lb_wr_valid) state_nxt = LD_D0;
      end
      LD_D0: begin
        lb_wr_en   = !req_sent;
        lb_addr    = LB_ADDR_W'(I2C_DATA_CACHE_BASE_ADDR);
        lb_wr_data = LB_DATA_W'(head.data[15:8]);
        if (lb_wr_valid) state_nxt = LD_D1;
      end
      LD_D1: begin
        lb_wr_en   = !req_sent;
        lb_addr    = LB_ADDR_W'(I2C_DATA_CACHE_BASE_ADDR + 8'd1);
        lb_wr_data = LB_DATA_W'(head.data[7:0]);
        if (lb_wr_valid) state_nxt = KICK;
      end
      KICK: begin
        lb_wr_en   = !req_sent;
        lb_addr    = LB_ADDR_W'(I2C_CONFIG_REG_ADDR);
        lb_wr_data = LB_DATA_W'(KICK_WORD);
        if (lb_wr_valid) state_nxt = POLL_RD;
      end
      POLL_RD: begin
        lb_rd_en = !req_sent;
        lb_addr  = LB_ADDR_W'(I2C_STATUS_REG_ADDR);
        if (lb_rd_valid) begin
          if (lb_rd_data[STAT_BUSY_BIT]) begin
            poll_inc = 1'b1;
            if (poll_cnt == PCW'(POLL_MAX - 1)) begin
              set_err   = 1'b1;
              err_val   = ERR_TIMEOUT;
              state_nxt = DONE;
            end else begin
              state_nxt = POLL_GAP_S;
            end
          end else begin
            nack_ld   = 1'b1;
            state_nxt = CHECK;
          end
        end
      end
      POLL_GAP_S: begin
        if (gap_cnt == GCW'(POLL_GAP - 1)) state_nxt = POLL_RD;
      end
      CHECK: begin
        state_nxt = DONE;
        if (!nack_lat) set_done = 1'b1;
`ifdef I2C_SEQ_RETRY_EN
        else if (retry_cnt < RCW'(MAX_RETRY)) begin
          retry_inc = 1'b1;
          poll_clr  = 1'b1;
          state_nxt = LD_ADDR;
        end
`endif
        else begin
          set_err = 1'b1;
          err_val = ERR_NACK;
        end
      end
      DONE: begin
        pop       = 1'b1;
        poll_clr  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_sent   <= 1'b0;
      shadow_vld <= 1'b0;
      div_shadow <= '0;
      div_sample <= '0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
      nack_lat   <= 1'b0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state <= state_nxt;
      // Request strobe fires once per state visit; any state change re-arms it.
      req_sent <= (state_nxt == state) && (req_sent || lb_wr_en || lb_rd_en);
      gap_cnt  <= (state == POLL_GAP_S && state_nxt == POLL_GAP_S) ? gap_cnt + 1'b1 : '0;
      if (state == IDLE) div_sample <= cfg_clk_div;
      if (shadow_ld) begin
        div_shadow <= div_sample;
        shadow_vld <= 1'b1;
      end
      if (poll_clr)      poll_cnt <= '0;
      else if (poll_inc) poll_cnt <= poll_cnt + 1'b1;
      if (nack_ld) nack_lat <= lb_rd_data[STAT_NACK_BIT];
      done_pulse <= set_done;
      err_pulse  <= set_err;
      if (set_err) err_code <= err_val;
    end
  end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Directed bench for i2c_seq_ctrl with a local-bus slave model (2-cycle response) and status model.
module tb_i2c_seq_ctrl;
  localparam int TB_POLL_GAP = 16;
  localparam int TB_POLL_MAX = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_dev_addr = '0;
  logic [15:0] cmd_data = '0;
  logic [7:0]  cfg_clk_div = 8'h20;
  logic        lb_wr_en, lb_rd_en;
  logic [7:0]  lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_wr_valid = 1'b0;
  logic        lb_rd_valid = 1'b0;
  logic [31:0] lb_rd_data = '0;
  logic        busy, done_pulse, err_pulse;
  logic [1:0]  err_code;

  i2c_seq_ctrl #(.POLL_GAP(TB_POLL_GAP), .POLL_MAX(TB_POLL_MAX)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev_addr(cmd_dev_addr), .cmd_data(cmd_data), .cfg_clk_div(cfg_clk_div),
    .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
    .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data),
    .busy(busy), .done_pulse(done_pulse), .err_pulse(err_pulse), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    logic [7:0] div; logic [6:0] dev; logic [15:0] dat; bit div_wr;
    logic [7:0] exp_a; logic [7:0] exp_d0; logic [7:0] exp_d1;
  } vec_t;

  wr_t wr_log[$];
  int  rd_cyc[$];
  int  checks = 0, failures = 0;
  int  done_cnt = 0, err_cnt = 0, proto_err = 0, cyc = 0;
  logic [1:0] last_err = '0;
  int  wr_timer = 0, rd_timer = 0;
  logic [31:0] rd_resp = '0;
  bit  prev_wr_en = 0;
  int  stat_busy_left = 0;
  bit  stat_busy_forever = 0, stat_nack = 0;

  // Local-bus slave and status register model; also counts pulses.
  always @(posedge clk) begin
    #1;
    cyc++;
    lb_wr_valid = 1'b0;
    lb_rd_valid = 1'b0;
    if (rst) begin
      wr_timer = 0; rd_timer = 0; prev_wr_en = 0;
    end else begin
      if (wr_timer > 0) begin wr_timer--; if (wr_timer == 0) lb_wr_valid = 1'b1; end
      if (rd_timer > 0) begin
        rd_timer--;
        if (rd_timer == 0) begin lb_rd_valid = 1'b1; lb_rd_data = rd_resp; end
      end
      if (lb_wr_en && lb_rd_en) proto_err++;
      if (lb_wr_en && prev_wr_en) proto_err++;
      prev_wr_en = lb_wr_en;
      if (lb_wr_en) begin wr_log.push_back('{lb_addr, lb_wr_data}); wr_timer = 2; end
      if (lb_rd_en) begin
        bit b;
        rd_cyc.push_back(cyc);
        rd_timer = 2;
        b = stat_busy_forever || (stat_busy_left > 0);
        if (stat_busy_left > 0) stat_busy_left--;
        rd_resp = {30'd0, stat_nack, b};
      end
      if (done_pulse) done_cnt++;
      if (err_pulse) begin err_cnt++; last_err = err_code; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [6:0] dev, input logic [15:0] dat);
    int n = 0;
    cmd_dev_addr = dev; cmd_data = dat; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_evt(input int target, input int budget, input string name);
    int n = 0;
    while ((done_cnt + err_cnt) < target && n < budget) begin @(negedge clk); n++; end
    checks++;
    if ((done_cnt + err_cnt) < target) begin
      failures++;
      $display("FAIL %s: no completion within %0d cycles (events=%0d want %0d)",
               name, budget, done_cnt + err_cnt, target);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic int count_addr(input logic [7:0] a);
    int c = 0;
    foreach (wr_log[k]) if (wr_log[k].addr == a) c++;
    return c;
  endfunction

  vec_t vecs[4];
  wr_t  exp_q[$];
  int   base, dbase, ebase, min_gap, acc, exp_kicks;
  bit   rdy_at_full;

  initial begin
    vecs[0] = '{8'h20, 7'h1A, 16'h1E00, 1'b1, 8'h34, 8'h1E, 8'h00};
    vecs[1] = '{8'h20, 7'h7F, 16'hA55A, 1'b0, 8'hFE, 8'hA5, 8'h5A};
    vecs[2] = '{8'h05, 7'h00, 16'hFFFF, 1'b1, 8'h00, 8'hFF, 8'hFF};
    vecs[3] = '{8'h05, 7'h55, 16'h0102, 1'b0, 8'hAA, 8'h01, 8'h02};

    repeat (3) @(negedge clk);
    chk("rst_wr_en", lb_wr_en, 0);     chk("rst_rd_en", lb_rd_en, 0);
    chk("rst_addr", lb_addr, 0);       chk("rst_wr_data", lb_wr_data, 0);
    chk("rst_busy", busy, 0);          chk("rst_done", done_pulse, 0);
    chk("rst_err", err_pulse, 0);      chk("rst_err_code", err_code, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Single-command write sequences, including divider rewrite when cfg changes.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wr_log.delete();
      cfg_clk_div = vecs[i].div;
      base = done_cnt + err_cnt; dbase = done_cnt;
      push_cmd(vecs[i].dev, vecs[i].dat);
      wait_evt(base + 1, 2000, $sformatf("vec%0d_wait", i));
      exp_q.delete();
      if (vecs[i].div_wr) exp_q.push_back('{8'h08, 32'(vecs[i].div)});
      exp_q.push_back('{8'h0C, 32'(vecs[i].exp_a)});
      exp_q.push_back('{8'h10, 32'(vecs[i].exp_d0)});
      exp_q.push_back('{8'h11, 32'(vecs[i].exp_d1)});
      exp_q.push_back('{8'h00, 32'h0000_0207});
      chk($sformatf("vec%0d_nwr", i), wr_log.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++)
        chk($sformatf("vec%0d_wr%0d", i, k), {wr_log[k].addr, wr_log[k].data[23:0]},
            {exp_q[k].addr, exp_q[k].data[23:0]});
      chk($sformatf("vec%0d_done", i), done_cnt, dbase + 1);
    end

    // Status busy for 5 polls.
    wr_log.delete(); rd_cyc.delete();
    stat_busy_left = 5;
    base = done_cnt + err_cnt; dbase = done_cnt;
    push_cmd(7'h22, 16'h1234);
    wait_evt(base + 1, 3000, "poll_wait");
    chk("poll_reads", rd_cyc.size(), 6);
    min_gap = 1000;
    for (int k = 1; k < rd_cyc.size(); k++)
      if (rd_cyc[k] - rd_cyc[k-1] < min_gap) min_gap = rd_cyc[k] - rd_cyc[k-1];
    chk("poll_gap_ok", (min_gap >= TB_POLL_GAP), 1);
    chk("poll_done", done_cnt, dbase + 1);

    // NACK on every attempt.
`ifdef I2C_SEQ_RETRY_EN
    exp_kicks = 4;
`else
    exp_kicks = 1;
`endif
    wr_log.delete();
    stat_nack = 1;
    base = done_cnt + err_cnt; dbase = done_cnt; ebase = err_cnt;
    push_cmd(7'h33, 16'h5566);
    wait_evt(base + 1, 3000, "nack_wait");
    stat_nack = 0;
    chk("nack_kicks", count_addr(8'h00), exp_kicks);
    chk("nack_err_cnt", err_cnt, ebase + 1);
    chk("nack_err_code", last_err, 1);
    chk("nack_no_done", done_cnt, dbase);

    // Busy forever -> timeout, then the queued command proceeds.
    wr_log.delete(); rd_cyc.delete();
    stat_busy_forever = 1;
    base = done_cnt + err_cnt; dbase = done_cnt; ebase = err_cnt;
    push_cmd(7'h44, 16'h0011);
    push_cmd(7'h45, 16'h2200);
    wait_evt(base + 1, 5000, "tmo_wait");
    stat_busy_forever = 0;
    chk("tmo_reads", rd_cyc.size(), TB_POLL_MAX);
    chk("tmo_err_code", last_err, 2);
    chk("tmo_err_cnt", err_cnt, ebase + 1);
    wait_evt(base + 2, 2000, "tmo_next_wait");
    chk("tmo_next_done", done_cnt, dbase + 1);
    chk("tmo_next_addr", {wr_log[wr_log.size()-4].addr, wr_log[wr_log.size()-4].data[7:0]},
        {8'h0C, 8'h8A});

    // Nine back-to-back pushes into an 8-deep FIFO.
    wr_log.delete();
    base = done_cnt + err_cnt; acc = 0; rdy_at_full = 1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      cmd_valid = 1'b1; cmd_dev_addr = 7'(16 + k); cmd_data = {8'(k), 8'hC3};
      if (cmd_ready) acc++;
      if (k == 8) rdy_at_full = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("fifo_accepted", acc, 8);
    chk("fifo_ready_full", rdy_at_full, 0);
    wait_evt(base + 8, 4000, "fifo_wait");
    chk("fifo_nkick", count_addr(8'h00), 8);
    begin
      int n = 0;
      foreach (wr_log[k]) if (wr_log[k].addr == 8'h0C) begin
        chk($sformatf("fifo_order%0d", n), wr_log[k].data, 32'(8'(32 + 2 * n)));
        n++;
      end
    end

    // Divider change mid-command, then reset during the poll gap.
    wr_log.delete(); rd_cyc.delete();
    stat_busy_left = 3;
    dbase = done_cnt; ebase = err_cnt;
    push_cmd(7'h2B, 16'hBEEF);
    begin
      int n = 0;
      while (rd_cyc.size() < 1 && n < 500) begin @(negedge clk); n++; end
    end
    chk("mid_first_read", rd_cyc.size(), 1);
    repeat (4) @(negedge clk);
    cfg_clk_div = 8'h33;
    repeat (3) @(negedge clk);
    chk("mid_no_div_wr", count_addr(8'h08), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_wr_en", lb_wr_en, 0);  chk("mid_rst_rd_en", lb_rd_en, 0);
    chk("mid_rst_addr", lb_addr, 0);    chk("mid_rst_wr_data", lb_wr_data, 0);
    chk("mid_rst_busy", busy, 0);       chk("mid_rst_err_code", err_code, 0);
    chk("mid_rst_done", done_pulse, 0); chk("mid_rst_err", err_pulse, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    stat_busy_left = 0;
    wr_log.delete();
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_rst_nwr", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("post_rst_div", {wr_log[0].addr, wr_log[0].data[23:0]}, 32'h0800_0033);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_no_pulse", done_cnt + err_cnt, dbase + ebase);
    wr_log.delete();
    base = done_cnt + err_cnt;
    push_cmd(7'h11, 16'h2233);
    wait_evt(base + 1, 2000, "post_rst_wait");
    chk("post_rst_cmd_nwr", wr_log.size(), 4);
    if (wr_log.size() > 0) chk("post_rst_cmd_addr", {wr_log[0].addr, wr_log[0].data[23:0]}, 32'h0C00_0022);
    chk("post_rst_done", done_cnt, dbase + 1);

    chk("lb_protocol", proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
